ex_mem_pipe_buf: RTL
====================

// Module: ex_mem_pipe_buf
// PURPOSE
//  Parametrised pipeline-stage register with valid/ready handshake and optional
//  2-entry skid buffer; successor to the fixed EX/MEM latch. Carries a control
//  word, NUM_BUSES data buses and a register address between stages. Supports
//  backpressure, synchronous flush (bubble insertion) and a stall-cycle counter.
//  Instantiated between any two MIPS pipeline stages; EX/MEM is the first user.
// PARAMETERS
//  CTRL_SIZE      8   control-word width (mem_rd_src, mem_wr_src, mem_write, wb, ...)
//  BUS_SIZE       32  width of each data bus
//  NUM_BUSES      2   data buses carried (e.g. bus_b, alu_result)
//  ADDR_SIZE      5   register write-address width
//  SKID           1   1: 2-entry skid buffer, registered o_ready; 0: single entry
//  FLUSH_DATA     0   1: flush also clears data/addr; 0: flush clears ctrl/valid only
//  STALL_CNT_SIZE 16  stall counter width
// PORTS
//  i_clk        in   1                    clock, rising edge
//  i_reset_n    in   1                    asynchronous reset, active-low
//  i_flush      in   1                    synchronous flush, drops all contents
//  i_cnt_clr    in   1                    synchronous clear of o_stall_cnt
//  i_valid      in   1                    upstream payload valid
//  o_ready      out  1                    this stage accepts payload
//  i_ctrl       in   CTRL_SIZE            control word
//  i_data       in   NUM_BUSES*BUS_SIZE   data buses, bus k at [k*BUS_SIZE +: BUS_SIZE]
//  i_addr_wr    in   ADDR_SIZE            register write address
//  o_valid      out  1                    output payload valid
//  i_ready      in   1                    downstream accepts payload
//  o_ctrl       out  CTRL_SIZE            control word, forced 0 when o_valid=0
//  o_data       out  NUM_BUSES*BUS_SIZE   data buses (not gated)
//  o_addr_wr    out  ADDR_SIZE            register write address (not gated)
//  o_stall_cnt  out  STALL_CNT_SIZE       cycles with o_valid=1 and i_ready=0
// BEHAVIOUR
//  - One clock i_clk; reset i_reset_n is asynchronous, active-low. Reset clears
//    every register: o_valid=0, o_ctrl=0, o_data=0, o_addr_wr=0, o_stall_cnt=0,
//    skid empty. o_ready=0 while i_reset_n=0; 1 in the first cycle after release.
//  - in_xfer = i_valid & o_ready; out_xfer = o_valid & i_ready. Latency 1 cycle.
//  - Storage: main entry (drives outputs) + skid entry (SKID=1 only).
//  - States: EMPTY (main invalid), ONE (main valid, skid empty), TWO (both valid).
//    EMPTY: in_xfer -> ONE, main<=in.
//    ONE: in&out -> ONE, main<=in; in&!out -> TWO, skid<=in;
//         !in&out -> EMPTY; neither -> hold.
//    TWO: out_xfer -> ONE, main<=skid; else hold. No input accepted.
//  - SKID=1: o_ready = !skid_valid (registered, no comb path from i_ready).
//    SKID=0: o_ready = !o_valid | i_ready (comb); TWO unreachable.
//  - Payload order strictly FIFO; no payload duplicated or dropped except by flush.
//  - i_flush (priority over all but reset): next state EMPTY, both valids 0,
//    stored ctrl cleared; data/addr cleared iff FLUSH_DATA=1. in_xfer in a flush
//    cycle is discarded. o_ready during flush follows the normal rule.
//  - o_stall_cnt: +1 each cycle o_valid & !i_ready; saturates at all-ones;
//    i_cnt_clr clears (clear wins over increment same cycle); flush does not clear.
//  - Hold cycles leave all stored fields unchanged (no X, no toggling).
// TESTING
//  - Reset mid-stream in TWO: i_reset_n=0 -> o_valid=0, o_ctrl=0, o_stall_cnt=0 async,
//    before next edge.
//  - Stream i_valid=1, i_ready=1, ctrl 0x01..0x10 -> same sequence out 1 cycle later,
//    o_ready=1 throughout, o_stall_cnt=0.
//  - SKID=1: send A,B with i_ready=0 -> TWO, o_ready=0, o_ctrl=A; raise i_ready ->
//    A then B out on consecutive cycles, o_ready back to 1; o_stall_cnt=stall cycles.
//  - SKID=0: i_ready=0 with o_valid=1 -> o_ready=0 same cycle; i_ready=1 with new
//    i_valid -> out_xfer and in_xfer same edge, no bubble.
//  - Flush in TWO with i_valid=1: next cycle o_valid=0, o_ctrl=0, input lost;
//    FLUSH_DATA=0 -> o_data holds old value; FLUSH_DATA=1 -> o_data=0.
//  - STALL_CNT_SIZE=4, hold i_ready=0 for 20 cycles -> o_stall_cnt stops at 15;
//    i_cnt_clr with stall same cycle -> 0.

Source files
------------

// File: rtl/ex_mem_pipe_buf.sv
// Pipeline-stage register with valid/ready handshake and optional two-entry skid buffer.
// Carries a control word, NUM_BUSES data buses and a register write address.
module ex_mem_pipe_buf #(
    parameter int CTRL_SIZE      = 8,
    parameter int BUS_SIZE       = 32,
    parameter int NUM_BUSES      = 2,
    parameter int ADDR_SIZE      = 5,
    parameter int SKID           = 1,
    parameter int FLUSH_DATA     = 0,
    parameter int STALL_CNT_SIZE = 16
) (
    input  logic                          i_clk,
    input  logic                          i_reset_n,
    input  logic                          i_flush,
    input  logic                          i_cnt_clr,
    input  logic                          i_valid,
    output logic                          o_ready,
    input  logic [CTRL_SIZE-1:0]          i_ctrl,
    input  logic [NUM_BUSES*BUS_SIZE-1:0] i_data,
    input  logic [ADDR_SIZE-1:0]          i_addr_wr,
    output logic                          o_valid,
    input  logic                          i_ready,
    output logic [CTRL_SIZE-1:0]          o_ctrl,
    output logic [NUM_BUSES*BUS_SIZE-1:0] o_data,
    output logic [ADDR_SIZE-1:0]          o_addr_wr,
    output logic [STALL_CNT_SIZE-1:0]     o_stall_cnt
);

    localparam int DATA_SIZE = NUM_BUSES * BUS_SIZE;

    logic                      main_vld_q, main_vld_d;
    logic                      skid_vld_q, skid_vld_d;
    logic [CTRL_SIZE-1:0]      main_ctrl_q, main_ctrl_d;
    logic [CTRL_SIZE-1:0]      skid_ctrl_q, skid_ctrl_d;
    logic [DATA_SIZE-1:0]      main_data_q, main_data_d;
    logic [DATA_SIZE-1:0]      skid_data_q, skid_data_d;
    logic [ADDR_SIZE-1:0]      main_addr_q, main_addr_d;
    logic [ADDR_SIZE-1:0]      skid_addr_q, skid_addr_d;
    logic [STALL_CNT_SIZE-1:0] stall_cnt_q, stall_cnt_d;

    logic ready_raw;
    logic in_xfer;
    logic out_xfer;

    // With the skid entry, ready depends only on stored state, breaking the i_ready path.
    always_comb begin
        if (SKID != 0) ready_raw = !skid_vld_q;
        else           ready_raw = !main_vld_q || i_ready;
    end

    assign o_ready  = i_reset_n && ready_raw;
    assign in_xfer  = i_valid && o_ready;
    assign out_xfer = main_vld_q && i_ready;

    always_comb begin
        main_vld_d  = main_vld_q;
        skid_vld_d  = skid_vld_q;
        main_ctrl_d = main_ctrl_q;
        skid_ctrl_d = skid_ctrl_q;
        main_data_d = main_data_q;
        skid_data_d = skid_data_q;
        main_addr_d = main_addr_q;
        skid_addr_d = skid_addr_q;

        if (i_flush) begin
            main_vld_d  = 1'b0;
            skid_vld_d  = 1'b0;
            main_ctrl_d = '0;
            skid_ctrl_d = '0;
            if (FLUSH_DATA != 0) begin
                main_data_d = '0;
                skid_data_d = '0;
                main_addr_d = '0;
                skid_addr_d = '0;
            end
        end else if (!main_vld_q) begin
            if (in_xfer) begin
                main_vld_d  = 1'b1;
                main_ctrl_d = i_ctrl;
                main_data_d = i_data;
                main_addr_d = i_addr_wr;
            end
        end else if (!skid_vld_q) begin
            if (in_xfer && out_xfer) begin
                main_ctrl_d = i_ctrl;
                main_data_d = i_data;
                main_addr_d = i_addr_wr;
            end else if (in_xfer && (SKID != 0)) begin
                skid_vld_d  = 1'b1;
                skid_ctrl_d = i_ctrl;
                skid_data_d = i_data;
                skid_addr_d = i_addr_wr;
            end else if (out_xfer) begin
                main_vld_d = 1'b0;
            end
        end else if (out_xfer) begin
            skid_vld_d  = 1'b0;
            main_ctrl_d = skid_ctrl_q;
            main_data_d = skid_data_q;
            main_addr_d = skid_addr_q;
        end
    end

    // Clear has priority; the counter sticks at all-ones instead of wrapping.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (i_cnt_clr)
            stall_cnt_d = '0;
        else if (main_vld_q && !i_ready && !(&stall_cnt_q))
            stall_cnt_d = stall_cnt_q + STALL_CNT_SIZE'(1);
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            main_vld_q  <= 1'b0;
            skid_vld_q  <= 1'b0;
            main_ctrl_q <= '0;
            skid_ctrl_q <= '0;
            main_data_q <= '0;
            skid_data_q <= '0;
            main_addr_q <= '0;
            skid_addr_q <= '0;
            stall_cnt_q <= '0;
        end else begin
            main_vld_q  <= main_vld_d;
            skid_vld_q  <= skid_vld_d;
            main_ctrl_q <= main_ctrl_d;
            skid_ctrl_q <= skid_ctrl_d;
            main_data_q <= main_data_d;
            skid_data_q <= skid_data_d;
            main_addr_q <= main_addr_d;
            skid_addr_q <= skid_addr_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign o_valid     = main_vld_q;
    assign o_ctrl      = main_vld_q ? main_ctrl_q : '0;
    assign o_data      = main_data_q;
    assign o_addr_wr   = main_addr_q;
    assign o_stall_cnt = stall_cnt_q;

endmodule
